snake_update_engine: RTL and testbench
======================================

Name: snake_update_engine

Overview:
- Parametrised successor to the snake game update FSM.
- Owns the snake body ring buffer, movement tick, and collision/score logic.
- Drives the tile-map write port and reads tiles for collision detection, so there are no hard-coded obstacle or fruit comparators.
- Adds border-wall mode, a speed ramp, pause, reversal rejection, length saturation, and a fruit-placement retry handshake.
- Sits between the direction decoder, fruit generator and tile-map RAM.

Parameters:
- MAPA_WIDTH, 40, map columns; 4..1023.
- MAPA_HEIGHT, 30, map rows; 4..1023.
- MAX_LEN, 128, body ring depth; power of two, >=4.
- WALLS, 0, 0 = edges wrap; 1 = border tiles are obstacles, no wrap.
- START_X, 10, initial head column; must lie inside the walls when WALLS=1.
- START_Y, 10, initial head row.
- TICK_INIT, 50000000, initial clocks per move.
- TICK_STEP, 1000000, period decrease per fruit eaten.
- TICK_MIN, 10000000, period floor.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a game / restarts after game over
- pause  in  1  level; freezes the tick counter
- cobra_dir  in  2  requested direction: 0 up, 1 down, 2 left, 3 right
- map_ren  out  1  tile read strobe
- map_rx  out  10  read column
- map_ry  out  10  read row
- map_rdata  in  2  tile code, valid exactly 1 cycle after map_ren
- map_wen  out  1  tile write strobe, one write per cycle
- map_wx  out  10  write column
- map_wy  out  10  write row
- map_wdata  out  2  tile code: 00 empty, 01 snake, 10 fruit, 11 obstacle
- fruta_req  out  1  fruit position request
- fruta_ack  in  1  generator response; fruta_x/fruta_y valid while high
- fruta_x  in  10  candidate fruit column
- fruta_y  in  10  candidate fruit row
- length  out  $clog2(MAX_LEN)+1  current body length
- score  out  20  fruits eaten this game
- high_score  out  20  best score since reset
- beating_high_score  out  1  score exceeded high_score this game
- game_over  out  1  held high in OVER
- ready  out  1  high in READY

Behaviour:
- Reset (async, active-high) values:
  - All strobes, score, high_score, beating_high_score, game_over, ready = 0; length = 1.
  - Tick period = TICK_INIT; last direction = 3 (right).
  - State = CLEAR with scan counters at 0.
- CLEAR:
  - Writes every tile in raster order, x fastest, one tile per cycle: 11 on border tiles if WALLS=1, otherwise 00.
  - Then writes 01 at (START_X, START_Y).
  - Takes W*H+1 cycles, then enters FRUIT.
  - Body ring is reset to one segment: head ptr = tail ptr = 0.
- FRUIT:
  - Asserts fruta_req and holds it until fruta_ack.
  - On ack, samples fruta_x/fruta_y, drops req, and reads that tile.
  - If the tile is 00: writes 10 there, stores the fruit position, and goes to READY (first fruit) or IDLE (during play).
  - Otherwise: req stays low for 1 cycle, then re-asserts.
- READY: ready = 1; a start pulse moves to IDLE.
- IDLE:
  - Tick counter increments unless pause = 1.
  - When counter reaches the period-1: counter clears, go to MOVE.
- MOVE:
  - If length > 1 and cobra_dir is the opposite of the last direction, keep the last direction; otherwise adopt cobra_dir.
  - Compute the new head. Wraps at edges when WALLS=0 (e.g. x=0 moving left gives MAPA_WIDTH-1).
  - Issue map_ren at the new head.
- CHECK (1 cycle after the read):
  - 11 → OVER.
  - 01 → OVER, unless the tile is the current tail and the move is not growing (the tail vacates it).
  - 10 → eat:
    - score + 1;
    - if score > high_score, then high_score = score and beating_high_score = 1;
    - period = max(period - TICK_STEP, TICK_MIN).
  - Grow when eating and length < MAX_LEN.
  - At length == MAX_LEN, eating scores but does not grow (tail advances); length saturates at MAX_LEN.
- ERASE: when not growing, writes 00 at the tail and advances the tail ptr modulo MAX_LEN. When growing, skips the write and increments length.
- HEAD:
  - Writes 01 at the new head and pushes it into the ring (head ptr + 1 mod MAX_LEN).
  - Next state is FRUIT if eaten, else IDLE.
- Latency: tick expiry to head write is 5 cycles (MOVE, READ, CHECK, ERASE, HEAD).
  - Erase always precedes the head write, so moving into the vacated tail tile leaves it 01.
- OVER:
  - game_over = 1; no map writes.
  - A start pulse clears score, beating_high_score, length (to 1), period (to TICK_INIT) and last direction, then enters CLEAR.
  - high_score is kept.
- start outside READY/OVER is ignored.
- pause outside IDLE is ignored; an in-flight move completes.
- Reset mid-CLEAR or mid-handshake: immediate return to CLEAR; fruta_req drops asynchronously.

Test Plan:
- Defaults, reset released → exactly 1201 map writes (1200 tiles of 00, then 01 at (10,10)), then fruta_req = 1.
- WALLS=1, 8x6 map → CLEAR writes 11 on all 24 border tiles; a head moving into x=0 ends in OVER, with no wrap write.
- WALLS=0, head at (0,5), dir = 2 → next head write is at (MAPA_WIDTH-1, 5); tail (1,5) is erased one cycle earlier.
- TICK_INIT=20, TICK_STEP=5, TICK_MIN=10; eat 3 fruits → tick periods 15, 10, 10; score = 3; high_score = 3; beating_high_score = 1.
- Fruit generator acks an occupied tile (01), then an empty one → req drops for 1 cycle and re-asserts; only the empty tile receives 10.
- MAX_LEN=4: eat 5 fruits in a line → length saturates at 4; score = 5; tail writes resume at the 4th eat. Moving right, then dir = 2 → reversal is ignored and the snake continues right.

Source files
------------

// File: rtl/snake_update_engine.sv
// rtl/snake_update_engine.sv - snake game update engine: body ring, movement tick, tile-map driven collision and score
// Owns the tile map contents through the write port; collisions are resolved by reading back the target tile.
module snake_update_engine #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int MAX_LEN     = 128,
    parameter int WALLS       = 0,
    parameter int START_X     = 10,
    parameter int START_Y     = 10,
    parameter int TICK_INIT   = 50000000,
    parameter int TICK_STEP   = 1000000,
    parameter int TICK_MIN    = 10000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pause,
    input  logic [1:0]                 cobra_dir,
    output logic                       map_ren,
    output logic [9:0]                 map_rx,
    output logic [9:0]                 map_ry,
    input  logic [1:0]                 map_rdata,
    output logic                       map_wen,
    output logic [9:0]                 map_wx,
    output logic [9:0]                 map_wy,
    output logic [1:0]                 map_wdata,
    output logic                       fruta_req,
    input  logic                       fruta_ack,
    input  logic [9:0]                 fruta_x,
    input  logic [9:0]                 fruta_y,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic [19:0]                score,
    output logic [19:0]                high_score,
    output logic                       beating_high_score,
    output logic                       game_over,
    output logic                       ready
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam logic [9:0]    XMAX    = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0]    YMAX    = 10'(MAPA_HEIGHT - 1);
    localparam logic [9:0]    SX      = 10'(START_X);
    localparam logic [9:0]    SY      = 10'(START_Y);
    localparam logic [31:0]   T_INIT  = 32'(TICK_INIT);
    localparam logic [31:0]   T_STEP  = 32'(TICK_STEP);
    localparam logic [31:0]   T_MIN   = 32'(TICK_MIN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [3:0] {
        S_CLEAR, S_CLEAR_HEAD, S_FRUIT_REQ, S_FRUIT_RD, S_FRUIT_CHK, S_FRUIT_GAP,
        S_READY, S_IDLE, S_MOVE, S_READ, S_CHECK, S_ERASE, S_HEAD, S_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      cx_q, cx_d, cy_q, cy_d;
    logic [9:0]      cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [9:0]      nx_q, nx_d, ny_q, ny_d;
    logic            first_q, first_d;
    logic [31:0]     tick_q, tick_d, period_q, period_d;
    logic [1:0]      dir_q, dir_d;
    logic [PW-1:0]   head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [19:0]     score_q, score_d, high_q, high_d;
    logic            beat_q, beat_d, eat_q, eat_d, grow_q, grow_d;

    logic [9:0]      ring_x_q [MAX_LEN];
    logic [9:0]      ring_y_q [MAX_LEN];
    logic            ring_we;
    logic [PW-1:0]   ring_wptr;
    logic [9:0]      ring_wx, ring_wy;

    logic            ren_c, wen_c, req_c;
    logic [9:0]      head_x, head_y, tail_x, tail_y;

    assign head_x = ring_x_q[head_ptr_q];
    assign head_y = ring_y_q[head_ptr_q];
    assign tail_x = ring_x_q[tail_ptr_q];
    assign tail_y = ring_y_q[tail_ptr_q];

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        first_d    = first_q;
        tick_d     = tick_q;
        period_d   = period_q;
        dir_d      = dir_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        len_d      = len_q;
        score_d    = score_q;
        high_d     = high_q;
        beat_d     = beat_q;
        eat_d      = eat_q;
        grow_d     = grow_q;
        ren_c      = 1'b0;
        wen_c      = 1'b0;
        req_c      = 1'b0;
        map_rx     = 10'd0;
        map_ry     = 10'd0;
        map_wx     = 10'd0;
        map_wy     = 10'd0;
        map_wdata  = 2'b00;
        ring_we    = 1'b0;
        ring_wptr  = head_ptr_q + PW'(1);
        ring_wx    = nx_q;
        ring_wy    = ny_q;

        case (state_q)
            S_CLEAR: begin
                wen_c  = 1'b1;
                map_wx = cx_q;
                map_wy = cy_q;
                if (WALLS != 0 && (cx_q == 10'd0 || cx_q == XMAX || cy_q == 10'd0 || cy_q == YMAX))
                    map_wdata = 2'b11;
                if (cx_q == XMAX) begin
                    cx_d = 10'd0;
                    if (cy_q == YMAX) begin
                        cy_d    = 10'd0;
                        state_d = S_CLEAR_HEAD;
                    end else begin
                        cy_d = cy_q + 10'd1;
                    end
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            S_CLEAR_HEAD: begin
                wen_c      = 1'b1;
                map_wx     = SX;
                map_wy     = SY;
                map_wdata  = 2'b01;
                ring_we    = 1'b1;
                ring_wptr  = '0;
                ring_wx    = SX;
                ring_wy    = SY;
                head_ptr_d = '0;
                tail_ptr_d = '0;
                first_d    = 1'b1;
                state_d    = S_FRUIT_REQ;
            end
            S_FRUIT_REQ: begin
                req_c = 1'b1;
                if (fruta_ack) begin
                    cand_x_d = fruta_x;
                    cand_y_d = fruta_y;
                    state_d  = S_FRUIT_RD;
                end
            end
            S_FRUIT_RD: begin
                ren_c   = 1'b1;
                map_rx  = cand_x_q;
                map_ry  = cand_y_q;
                state_d = S_FRUIT_CHK;
            end
            S_FRUIT_CHK: begin
                if (map_rdata == 2'b00) begin
                    wen_c     = 1'b1;
                    map_wx    = cand_x_q;
                    map_wy    = cand_y_q;
                    map_wdata = 2'b10;
                    first_d   = 1'b0;
                    state_d   = first_q ? S_READY : S_IDLE;
                end else begin
                    state_d = S_FRUIT_GAP;
                end
            end
            S_FRUIT_GAP: state_d = S_FRUIT_REQ;
            S_READY: if (start) state_d = S_IDLE;
            S_IDLE: begin
                if (!pause) begin
                    if (tick_q == period_q - 32'd1) begin
                        tick_d  = 32'd0;
                        state_d = S_MOVE;
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
            end
            S_MOVE: begin
                // A direct reversal would run the head straight into the neck.
                dir_d = (len_q > LW'(1) && cobra_dir == (dir_q ^ 2'b01)) ? dir_q : cobra_dir;
                nx_d  = head_x;
                ny_d  = head_y;
                case (dir_d)
                    2'd0:    ny_d = (head_y == 10'd0) ? YMAX : head_y - 10'd1;
                    2'd1:    ny_d = (head_y == YMAX) ? 10'd0 : head_y + 10'd1;
                    2'd2:    nx_d = (head_x == 10'd0) ? XMAX : head_x - 10'd1;
                    default: nx_d = (head_x == XMAX) ? 10'd0 : head_x + 10'd1;
                endcase
                state_d = S_READ;
            end
            S_READ: begin
                ren_c   = 1'b1;
                map_rx  = nx_q;
                map_ry  = ny_q;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                eat_d   = 1'b0;
                grow_d  = 1'b0;
                state_d = S_ERASE;
                case (map_rdata)
                    2'b11: state_d = S_OVER;
                    2'b01: if (nx_q != tail_x || ny_q != tail_y) state_d = S_OVER;
                    2'b10: begin
                        eat_d   = 1'b1;
                        grow_d  = (len_q < LEN_MAX);
                        score_d = score_q + 20'd1;
                        if (score_d > high_q) begin
                            high_d = score_d;
                            beat_d = 1'b1;
                        end
                        period_d = (period_q >= T_MIN + T_STEP) ? period_q - T_STEP : T_MIN;
                    end
                    default: ;
                endcase
            end
            S_ERASE: begin
                if (grow_q) begin
                    len_d = len_q + LW'(1);
                end else begin
                    wen_c      = 1'b1;
                    map_wx     = tail_x;
                    map_wy     = tail_y;
                    tail_ptr_d = tail_ptr_q + PW'(1);
                end
                state_d = S_HEAD;
            end
            S_HEAD: begin
                wen_c      = 1'b1;
                map_wx     = nx_q;
                map_wy     = ny_q;
                map_wdata  = 2'b01;
                ring_we    = 1'b1;
                head_ptr_d = head_ptr_q + PW'(1);
                state_d    = eat_q ? S_FRUIT_REQ : S_IDLE;
            end
            S_OVER: begin
                if (start) begin
                    score_d  = 20'd0;
                    beat_d   = 1'b0;
                    len_d    = LW'(1);
                    period_d = T_INIT;
                    dir_d    = 2'd3;
                    tick_d   = 32'd0;
                    cx_d     = 10'd0;
                    cy_d     = 10'd0;
                    state_d  = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            cx_q       <= 10'd0;
            cy_q       <= 10'd0;
            cand_x_q   <= 10'd0;
            cand_y_q   <= 10'd0;
            nx_q       <= 10'd0;
            ny_q       <= 10'd0;
            first_q    <= 1'b1;
            tick_q     <= 32'd0;
            period_q   <= T_INIT;
            dir_q      <= 2'd3;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            len_q      <= LW'(1);
            score_q    <= 20'd0;
            high_q     <= 20'd0;
            beat_q     <= 1'b0;
            eat_q      <= 1'b0;
            grow_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            first_q    <= first_d;
            tick_q     <= tick_d;
            period_q   <= period_d;
            dir_q      <= dir_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            len_q      <= len_d;
            score_q    <= score_d;
            high_q     <= high_d;
            beat_q     <= beat_d;
            eat_q      <= eat_d;
            grow_q     <= grow_d;
        end
    end

    // Body storage is plain memory; only slot 0 is meaningful after CLEAR.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_x_q[ring_wptr] <= ring_wx;
            ring_y_q[ring_wptr] <= ring_wy;
        end
    end

    assign map_ren            = ren_c & ~reset;
    assign map_wen            = wen_c & ~reset;
    assign fruta_req          = req_c & ~reset;
    assign length             = len_q;
    assign score              = score_q;
    assign high_score         = high_q;
    assign beating_high_score = beat_q;
    assign game_over          = (state_q == S_OVER);
    assign ready              = (state_q == S_READY);

endmodule

// File: tb/tb_snake_update_engine.sv
// tb/tb_snake_update_engine.sv - directed bench: wrapping 40x30 engine and walled 8x6 engine against tile-map models
module tb_snake_update_engine;

    typedef struct {
        int inst;
        int cyc;
        int x;
        int y;
        int d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       pause [2];
    logic [1:0] cobra_dir [2];
    logic       map_ren [2];
    logic [9:0] map_rx [2];
    logic [9:0] map_ry [2];
    logic [1:0] map_rdata [2];
    logic       map_wen [2];
    logic [9:0] map_wx [2];
    logic [9:0] map_wy [2];
    logic [1:0] map_wdata [2];
    logic       fruta_req [2];
    logic       fruta_ack [2];
    logic [9:0] fruta_x [2];
    logic [9:0] fruta_y [2];
    logic [2:0] length [2];
    logic [19:0] score [2];
    logic [19:0] high_score [2];
    logic       beating [2];
    logic       game_over [2];
    logic       ready [2];

    logic [1:0] tile [2][4096];
    ev_t        wq[$];
    ev_t        rq[$];
    int         cyc = 0;
    int         scan = 0;
    int         rscan = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    snake_update_engine #(
        .MAPA_WIDTH(40), .MAPA_HEIGHT(30), .MAX_LEN(4), .WALLS(0), .START_X(10), .START_Y(10),
        .TICK_INIT(20), .TICK_STEP(5), .TICK_MIN(10)
    ) u_wrap (
        .clk(clk), .reset(rst), .start(start[0]), .pause(pause[0]), .cobra_dir(cobra_dir[0]),
        .map_ren(map_ren[0]), .map_rx(map_rx[0]), .map_ry(map_ry[0]), .map_rdata(map_rdata[0]),
        .map_wen(map_wen[0]), .map_wx(map_wx[0]), .map_wy(map_wy[0]), .map_wdata(map_wdata[0]),
        .fruta_req(fruta_req[0]), .fruta_ack(fruta_ack[0]), .fruta_x(fruta_x[0]), .fruta_y(fruta_y[0]),
        .length(length[0]), .score(score[0]), .high_score(high_score[0]),
        .beating_high_score(beating[0]), .game_over(game_over[0]), .ready(ready[0])
    );

    snake_update_engine #(
        .MAPA_WIDTH(8), .MAPA_HEIGHT(6), .MAX_LEN(4), .WALLS(1), .START_X(2), .START_Y(2),
        .TICK_INIT(20), .TICK_STEP(5), .TICK_MIN(10)
    ) u_wall (
        .clk(clk), .reset(rst), .start(start[1]), .pause(pause[1]), .cobra_dir(cobra_dir[1]),
        .map_ren(map_ren[1]), .map_rx(map_rx[1]), .map_ry(map_ry[1]), .map_rdata(map_rdata[1]),
        .map_wen(map_wen[1]), .map_wx(map_wx[1]), .map_wy(map_wy[1]), .map_wdata(map_wdata[1]),
        .fruta_req(fruta_req[1]), .fruta_ack(fruta_ack[1]), .fruta_x(fruta_x[1]), .fruta_y(fruta_y[1]),
        .length(length[1]), .score(score[1]), .high_score(high_score[1]),
        .beating_high_score(beating[1]), .game_over(game_over[1]), .ready(ready[1])
    );

    function automatic int adr(input int x, input int y);
        return y * 64 + x;
    endfunction

    // Tile-map RAM model: 1-cycle read latency, logs every access.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst && map_wen[i]) begin
                tile[i][adr(int'(map_wx[i]), int'(map_wy[i]))] <= map_wdata[i];
                wq.push_back('{i, cyc, int'(map_wx[i]), int'(map_wy[i]), int'(map_wdata[i])});
            end
            if (!rst && map_ren[i]) begin
                map_rdata[i] <= tile[i][adr(int'(map_rx[i]), int'(map_ry[i]))];
                rq.push_back('{i, cyc, int'(map_rx[i]), int'(map_ry[i]), 0});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic give_fruit(input int i, input int x, input int y);
        int n = 0;
        while (fruta_req[i] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("fruit_req_seen", 32'(fruta_req[i]), 1);
        fruta_x[i]   = 10'(x);
        fruta_y[i]   = 10'(y);
        fruta_ack[i] = 1'b1;
        @(negedge clk);
        fruta_ack[i] = 1'b0;
    endtask

    task automatic find_wr(input int i, input int d, output ev_t e, output int idx);
        int  n = 0;
        bit  found = 0;
        e   = '{-1, -1, -1, -1, -1};
        idx = 0;
        while (!found && n < 3000) begin
            while (scan < wq.size() && !found) begin
                if (wq[scan].inst == i && wq[scan].d == d) begin
                    e     = wq[scan];
                    idx   = scan;
                    found = 1;
                end
                scan++;
            end
            if (!found) begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) chk("write_timeout", 0, 1);
    endtask

    task automatic find_rd(input int i, input int after, output ev_t e);
        int  n = 0;
        bit  found = 0;
        e = '{-1, -1, -1, -1, -1};
        while (!found && n < 3000) begin
            while (rscan < rq.size() && !found) begin
                if (rq[rscan].inst == i && rq[rscan].cyc > after) begin
                    e     = rq[rscan];
                    found = 1;
                end
                rscan++;
            end
            if (!found) begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) chk("read_timeout", 0, 1);
    endtask

    // Place a fruit, then measure fruit-write to next move-read spacing (period + 2).
    task automatic place_measure(input int x, input int y, input int exp_gap, input string tag);
        ev_t fw, rd;
        int  idx;
        give_fruit(0, x, y);
        find_wr(0, 2, fw, idx);
        chk({tag, "_fx"}, fw.x, x);
        find_rd(0, fw.cyc, rd);
        chk(tag, rd.cyc - fw.cyc, exp_gap);
    endtask

    initial begin
        ev_t e, last0, last1;
        int  idx, n, bad, c11, r0;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; pause[i] = 1'b0; cobra_dir[i] = 2'd3;
            fruta_ack[i] = 1'b0; fruta_x[i] = 10'd0; fruta_y[i] = 10'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_length", 32'(length[i]), 1);
            chk("rst_score", 32'(score[i]), 0);
            chk("rst_high", 32'(high_score[i]), 0);
            chk("rst_beat", 32'(beating[i]), 0);
            chk("rst_over", 32'(game_over[i]), 0);
            chk("rst_ready", 32'(ready[i]), 0);
            chk("rst_wen", 32'(map_wen[i]), 0);
            chk("rst_req", 32'(fruta_req[i]), 0);
        end
        rst = 1'b0;

        n = 0;
        while (fruta_req[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("clr_req_after", 32'(fruta_req[0]), 1);

        // Raster order, x fastest; then the start tile.
        n = 0; bad = 0; last0 = '{-1, -1, -1, -1, -1};
        foreach (wq[j]) if (wq[j].inst == 0) begin
            if (n < 1200) begin
                if (wq[j].x != n % 40 || wq[j].y != n / 40 || wq[j].d != 0) bad++;
            end else last0 = wq[j];
            n++;
        end
        chk("clr_writes", n, 1201);
        chk("clr_raster", bad, 0);
        chk("clr_head_x", last0.x, 10);
        chk("clr_head_y", last0.y, 10);
        chk("clr_head_d", last0.d, 1);

        n = 0; bad = 0; c11 = 0; last1 = '{-1, -1, -1, -1, -1};
        foreach (wq[j]) if (wq[j].inst == 1) begin
            if (n < 48) begin
                if (wq[j].x != n % 8 || wq[j].y != n / 8) bad++;
                if (wq[j].d != (((n % 8) == 0 || (n % 8) == 7 || (n / 8) == 0 || (n / 8) == 5) ? 3 : 0)) bad++;
                if (wq[j].d == 3) c11++;
            end else last1 = wq[j];
            n++;
        end
        chk("wall_clr_writes", n, 49);
        chk("wall_clr_border", c11, 24);
        chk("wall_clr_codes", bad, 0);
        chk("wall_clr_head_x", last1.x, 2);
        chk("wall_clr_head_y", last1.y, 2);
        scan  = wq.size();
        rscan = rq.size();

        // Occupied candidate is rejected, then req drops one cycle and re-asserts.
        give_fruit(0, 10, 10);
        @(negedge clk);
        @(negedge clk);
        chk("retry_gap_low", 32'(fruta_req[0]), 0);
        @(negedge clk);
        chk("retry_reassert", 32'(fruta_req[0]), 1);
        give_fruit(0, 11, 10);
        find_wr(0, 2, e, idx);
        chk("fruit1_x", e.x, 11);
        chk("fruit1_y", e.y, 10);
        chk("occupied_kept", 32'(tile[0][adr(10, 10)]), 1);
        chk("ready_high", 32'(ready[0]), 1);

        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("ready_low", 32'(ready[0]), 0);

        // Eat along row 10; periods 20 -> 15 -> 10 -> 10.
        place_measure(12, 10, 17, "period_15");
        place_measure(13, 10, 12, "period_10a");
        chk("grow_len2_3", 32'(length[0]), 3);
        place_measure(14, 10, 12, "period_10b");
        chk("score_3", 32'(score[0]), 3);
        chk("high_3", 32'(high_score[0]), 3);
        chk("beat_1", 32'(beating[0]), 1);
        chk("len_4", 32'(length[0]), 4);
        find_wr(0, 0, e, idx);
        chk("eat4_tail_x", e.x, 10);
        chk("eat4_tail_y", e.y, 10);
        place_measure(15, 10, 12, "period_10c");
        find_wr(0, 0, e, idx);
        chk("eat5_tail_x", e.x, 11);
        find_wr(0, 1, e, idx);
        chk("eat5_head_x", e.x, 15);
        give_fruit(0, 30, 20);
        chk("score_5", 32'(score[0]), 5);
        chk("len_sat_4", 32'(length[0]), 4);
        chk("high_5", 32'(high_score[0]), 5);

        // Reversal to the left is rejected; then up one row and left across the wrap.
        cobra_dir[0] = 2'd2;
        find_wr(0, 1, e, idx);
        chk("reverse_x", e.x, 16);
        chk("reverse_y", e.y, 10);
        cobra_dir[0] = 2'd0;
        find_wr(0, 1, e, idx);
        chk("up_y", e.y, 9);
        cobra_dir[0] = 2'd2;
        bad = 0;
        for (int x = 15; x >= 0; x--) begin
            find_wr(0, 1, e, idx);
            if (e.x != x || e.y != 9) bad++;
            if (x == 8) begin
                pause[0] = 1'b1;
                r0 = rq.size();
                repeat (40) @(negedge clk);
                chk("pause_no_move", rq.size() - r0, 0);
                pause[0] = 1'b0;
            end
        end
        chk("left_path", bad, 0);
        find_wr(0, 1, e, idx);
        chk("wrap_x", e.x, 39);
        chk("wrap_y", e.y, 9);
        chk("wrap_erase_x", wq[idx - 1].x, 3);
        chk("wrap_erase_d", wq[idx - 1].d, 0);
        chk("wrap_erase_cyc", e.cyc - wq[idx - 1].cyc, 1);

        // Walled map: eat at (1,2), then run into the x=0 border.
        give_fruit(1, 1, 2);
        find_wr(1, 2, e, idx);
        chk("wall_fruit_x", e.x, 1);
        chk("wall_ready", 32'(ready[1]), 1);
        cobra_dir[1] = 2'd2;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        find_wr(1, 1, e, idx);
        chk("wall_head_x", e.x, 1);
        chk("wall_score", 32'(score[1]), 1);
        chk("wall_len", 32'(length[1]), 2);
        give_fruit(1, 5, 4);
        r0 = wq.size();
        n = 0;
        while (game_over[1] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wall_over", 32'(game_over[1]), 1);
        bad = 0;
        for (int j = r0; j < wq.size(); j++)
            if (wq[j].inst == 1 && (wq[j].d != 2 || wq[j].x == 0 || wq[j].x == 7)) bad++;
        chk("wall_no_wrap_write", bad, 0);
        chk("wall_high_1", 32'(high_score[1]), 1);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("restart_over_low", 32'(game_over[1]), 0);
        chk("restart_score", 32'(score[1]), 0);
        chk("restart_high_kept", 32'(high_score[1]), 1);
        chk("restart_beat", 32'(beating[1]), 0);
        chk("restart_len", 32'(length[1]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
